// File: rtl/controlador_exibicao_sequencia.sv
// -----------------------------------------------------------------------------
// controlador_exibicao_sequencia
//
// Plays back a stored LED sequence one step at a time.
//
// For each address from 0 up to the round limit, the block:
//   - reads the LED code from the sequence memory,
//   - keeps that code lit for a fixed number of cycles,
//   - then keeps the LEDs dark for a fixed number of cycles.
// After the last step it emits a one-cycle completion pulse.
// Two timing sets are provided: normal and demo.
//
// Ports
//   clock        in   system clock, rising edge
//   reset        in   synchronous, active-high reset
//   iniciar      in   start request, honoured only while idle
//   parar        in   synchronous abort; returns to idle without completing
//   limite[3:0]  in   last memory address of the round, captured at start
//   modo_demo    in   selects demo timing, captured at start
//   dado_memoria in   LED code from the sequence memory
//   endereco     out  memory read address (registered)
//   leds         out  LED drive, non-zero only while a step is lit
//   exibindo     out  high while a sequence is being shown
//   pronto       out  one-cycle completion pulse
//   db_estado    out  current state code for debug
//
// The memory sees a registered address. The read data is therefore valid
// during the whole single-cycle load state, and it is captured at the end of
// that state.
//
// All timing parameters must be at least 1.
// -----------------------------------------------------------------------------
module controlador_exibicao_sequencia #(
  parameter int T_ACESO        = 500,
  parameter int T_APAGADO      = 250,
  parameter int T_ACESO_DEMO   = 50,
  parameter int T_APAGADO_DEMO = 25
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       parar,
  input  logic [3:0] limite,
  input  logic       modo_demo,
  input  logic [3:0] dado_memoria,
  output logic [3:0] endereco,
  output logic [3:0] leds,
  output logic       exibindo,
  output logic       pronto,
  output logic [2:0] db_estado
);

  // The duration counter counts down from T-1 to 0.
  // It only ever holds values below the largest parameter.
  localparam int T_MAX_N = (T_ACESO > T_APAGADO) ? T_ACESO : T_APAGADO;
  localparam int T_MAX_D = (T_ACESO_DEMO > T_APAGADO_DEMO) ? T_ACESO_DEMO : T_APAGADO_DEMO;
  localparam int T_MAX   = (T_MAX_N > T_MAX_D) ? T_MAX_N : T_MAX_D;
  localparam int CNT_W   = (T_MAX > 1) ? $clog2(T_MAX) : 1;

  localparam logic [CNT_W-1:0] CARGA_ACESO        = CNT_W'(T_ACESO - 1);
  localparam logic [CNT_W-1:0] CARGA_APAGADO      = CNT_W'(T_APAGADO - 1);
  localparam logic [CNT_W-1:0] CARGA_ACESO_DEMO   = CNT_W'(T_ACESO_DEMO - 1);
  localparam logic [CNT_W-1:0] CARGA_APAGADO_DEMO = CNT_W'(T_APAGADO_DEMO - 1);

  typedef enum logic [2:0] {
    OCIOSO  = 3'd0,
    CARREGA = 3'd1,
    ACESO   = 3'd2,
    APAGADO = 3'd3,
    FIM     = 3'd4
  } estado_t;

  estado_t          estado, estado_prox;
  logic [CNT_W-1:0] contador, contador_prox;
  logic [3:0]       endereco_prox;
  logic [3:0]       dado_reg, dado_prox;
  logic [3:0]       limite_reg, limite_prox;
  logic             modo_reg, modo_prox;
  logic [CNT_W-1:0] carga_aceso, carga_apagado;

  // Timing for the current round comes from the mode captured at start.
  // Later changes on modo_demo therefore cannot stretch or shorten a
  // playback that is already running.
  always_comb begin
    carga_aceso   = modo_reg ? CARGA_ACESO_DEMO   : CARGA_ACESO;
    carga_apagado = modo_reg ? CARGA_APAGADO_DEMO : CARGA_APAGADO;
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      estado <= OCIOSO;
    end else begin
      estado <= estado_prox;
    end
  end

  // Datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      contador   <= '0;
      endereco   <= '0;
      dado_reg   <= '0;
      limite_reg <= '0;
      modo_reg   <= 1'b0;
    end else begin
      contador   <= contador_prox;
      endereco   <= endereco_prox;
      dado_reg   <= dado_prox;
      limite_reg <= limite_prox;
      modo_reg   <= modo_prox;
    end
  end

  // Next-state and datapath update
  always_comb begin
    estado_prox   = estado;
    contador_prox = contador;
    endereco_prox = endereco;
    dado_prox     = dado_reg;
    limite_prox   = limite_reg;
    modo_prox     = modo_reg;

    if (parar) begin
      // Abort wins over everything except reset.
      // When idle, it also masks a simultaneous start request.
      estado_prox   = OCIOSO;
      contador_prox = '0;
    end else begin
      unique case (estado)
        OCIOSO: begin
          if (iniciar) begin
            estado_prox   = CARREGA;
            contador_prox = '0;
            endereco_prox = '0;
            limite_prox   = limite;
            modo_prox     = modo_demo;
          end
        end

        CARREGA: begin
          dado_prox     = dado_memoria;
          estado_prox   = ACESO;
          contador_prox = carga_aceso;
        end

        ACESO: begin
          if (contador == '0) begin
            estado_prox   = APAGADO;
            contador_prox = carga_apagado;
          end else begin
            contador_prox = contador - 1'b1;
          end
        end

        APAGADO: begin
          if (contador == '0) begin
            contador_prox = '0;
            // Compare before incrementing. With limite=15 the round ends
            // at address 15, so the address never wraps back to 0.
            if (endereco == limite_reg) begin
              estado_prox = FIM;
            end else begin
              estado_prox   = CARREGA;
              endereco_prox = endereco + 4'd1;
            end
          end else begin
            contador_prox = contador - 1'b1;
          end
        end

        FIM: begin
          estado_prox   = OCIOSO;
          contador_prox = '0;
        end

        default: begin
          estado_prox   = OCIOSO;
          contador_prox = '0;
        end
      endcase
    end
  end

  // Outputs decode only the registered state.
  // They are therefore glitch-free and change only on clock edges.
  always_comb begin
    leds      = 4'b0000;
    exibindo  = 1'b0;
    pronto    = 1'b0;
    db_estado = estado;
    unique case (estado)
      CARREGA: exibindo = 1'b1;
      ACESO: begin
        exibindo = 1'b1;
        leds     = dado_reg;
      end
      APAGADO: exibindo = 1'b1;
      FIM:     pronto   = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_controlador_exibicao_sequencia.sv
module tb_controlador_exibicao_sequencia;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       iniciar = 1'b0;
  logic       parar = 1'b0;
  logic [3:0] limite = 4'd0;
  logic       modo_demo = 1'b0;
  logic [3:0] dado_memoria;
  logic [3:0] endereco;
  logic [3:0] leds;
  logic       exibindo;
  logic       pronto;
  logic [2:0] db_estado;

  int checks = 0;
  int passed = 0;

  always #5 clock = ~clock;

  controlador_exibicao_sequencia #(
    .T_ACESO(8), .T_APAGADO(4), .T_ACESO_DEMO(2), .T_APAGADO_DEMO(1)
  ) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .parar(parar),
    .limite(limite), .modo_demo(modo_demo), .dado_memoria(dado_memoria),
    .endereco(endereco), .leds(leds), .exibindo(exibindo), .pronto(pronto),
    .db_estado(db_estado)
  );

  // Sequence memory: mem[i] = one-hot(i mod 4), looked up from the registered address.
  assign dado_memoria = 4'b0001 << endereco[1:0];

  // Observed bundle: {leds, pronto, exibindo, db_estado, endereco}
  logic [12:0] obs;
  assign obs = {leds, pronto, exibindo, db_estado, endereco};

  // Reference model.
  // t counts cycles after the edge that sampled iniciar: t=1 is the first
  // load cycle. Each step takes P = 1 + Ta + Tp cycles. The pronto pulse
  // falls at t = n*P + 1, and the block is idle after that.
  function automatic logic [12:0] model(input int t, input int lim, input bit demo);
    int ta, tp, p, n, i, r;
    logic [3:0] l, e;
    logic pr, ex;
    logic [2:0] st;
    ta = demo ? 2 : 8;
    tp = demo ? 1 : 4;
    p  = 1 + ta + tp;
    n  = lim + 1;
    l = 4'b0; pr = 1'b0; ex = 1'b0; st = 3'd0; e = 4'(lim);
    if (t <= n * p) begin
      i  = (t - 1) / p;
      r  = (t - 1) % p;
      e  = 4'(i);
      ex = 1'b1;
      if (r == 0) st = 3'd1;
      else if (r <= ta) begin
        st = 3'd2;
        l  = 4'b0001 << (i % 4);
      end else st = 3'd3;
    end else if (t == n * p + 1) begin
      st = 3'd4;
      pr = 1'b1;
    end
    return {l, pr, ex, st, e};
  endfunction

  // Expected bundle after an abort in step i: idle, dark, address held at i.
  function automatic logic [12:0] idle_at(input int i);
    return {4'b0, 1'b0, 1'b0, 3'd0, 4'(i)};
  endfunction

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; iniciar = 1'b0; parar = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Present a start request and return just after the sampling edge.
  task automatic start(input int lim, input bit demo);
    @(negedge clock);
    limite = 4'(lim); modo_demo = demo; iniciar = 1'b1;
    @(posedge clock);
    #1 iniciar = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; iniciar = 1'b1; parar = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if (obs !== 13'd0) $display("FAIL reset_state: got %h want %h", obs, 13'd0);
    else passed++;
    reset = 1'b0; iniciar = 1'b0;
    repeat (3) begin
      @(negedge clock);
      checks++;
      if (obs !== 13'd0) $display("FAIL idle_after_reset: got %h want %h", obs, 13'd0);
      else passed++;
    end
  endtask

  task automatic test_single_step();
    logic [12:0] exp;
    start(0, 1'b0);
    for (int t = 1; t <= 18; t++) begin
      @(negedge clock);
      exp = model(t, 0, 1'b0);
      checks++;
      if (obs !== exp) $display("FAIL single_step t=%0d: got %h want %h", t, obs, exp);
      else passed++;
    end
  endtask

  task automatic test_demo();
    logic [12:0] exp;
    start(3, 1'b1);
    for (int t = 1; t <= 20; t++) begin
      @(negedge clock);
      exp = model(t, 3, 1'b1);
      checks++;
      if (obs !== exp) $display("FAIL demo t=%0d: got %h want %h", t, obs, exp);
      else passed++;
    end
  endtask

  task automatic test_abort();
    logic [12:0] exp;
    start(3, 1'b0);
    for (int t = 1; t <= 60; t++) begin
      @(negedge clock);
      exp = (t <= 20) ? model(t, 3, 1'b0) : idle_at(1);
      checks++;
      if (obs !== exp) $display("FAIL abort t=%0d: got %h want %h", t, obs, exp);
      else passed++;
      if (t == 20) parar = 1'b1;
      if (t == 21) parar = 1'b0;
    end
  endtask

  task automatic test_parar_priority();
    @(negedge clock);
    parar = 1'b1; iniciar = 1'b1;
    repeat (3) begin
      @(negedge clock);
      checks++;
      if (db_estado !== 3'd0 || exibindo !== 1'b0)
        $display("FAIL parar_priority: got estado=%0d exib=%b want 0 0", db_estado, exibindo);
      else passed++;
    end
    parar = 1'b0; iniciar = 1'b0;
  endtask

  task automatic test_ignored_inputs();
    logic [12:0] exp;
    @(negedge clock);
    limite = 4'd2; modo_demo = 1'b0; iniciar = 1'b1;
    @(posedge clock);
    #1 limite = 4'd0; modo_demo = 1'b1;   // iniciar stays high
    for (int t = 1; t <= 46; t++) begin
      @(negedge clock);
      exp = (t <= 41) ? model(t, 2, 1'b0) : model(t - 41, 0, 1'b1);
      checks++;
      if (obs !== exp) $display("FAIL ignored_inputs t=%0d: got %h want %h", t, obs, exp);
      else passed++;
      if (t == 46) iniciar = 1'b0;
    end
    @(negedge clock);
    checks++;
    if (obs !== idle_at(0)) $display("FAIL ignored_inputs_end: got %h want %h", obs, idle_at(0));
    else passed++;
  endtask

  task automatic test_reset_mid();
    logic [12:0] exp;
    start(3, 1'b0);
    for (int t = 1; t <= 8; t++) begin
      @(negedge clock);
      exp = (t <= 5) ? model(t, 3, 1'b0) : 13'd0;
      checks++;
      if (obs !== exp) $display("FAIL reset_mid t=%0d: got %h want %h", t, obs, exp);
      else passed++;
      if (t == 5) reset = 1'b1;
      if (t == 6) reset = 1'b0;
    end
    start(1, 1'b1);
    for (int t = 1; t <= 11; t++) begin
      @(negedge clock);
      exp = model(t, 1, 1'b1);
      checks++;
      if (obs !== exp) $display("FAIL replay_after_reset t=%0d: got %h want %h", t, obs, exp);
      else passed++;
    end
  endtask

  task automatic test_no_wrap();
    logic [12:0] exp;
    int last_addr;
    last_addr = 0;
    start(15, 1'b1);
    for (int t = 1; t <= 68; t++) begin
      @(negedge clock);
      exp = model(t, 15, 1'b1);
      checks++;
      if (obs !== exp) $display("FAIL no_wrap t=%0d: got %h want %h", t, obs, exp);
      else passed++;
      if (t <= 65) begin
        checks++;
        if (int'(endereco) < last_addr)
          $display("FAIL no_wrap_monotonic t=%0d: got %0d want >=%0d", t, endereco, last_addr);
        else passed++;
        last_addr = int'(endereco);
      end
    end
  endtask

  task automatic test_random();
    logic [12:0] exp;
    int lim, p, n, abort_t, a_step;
    bit demo;
    for (int run = 0; run < 8; run++) begin
      lim  = int'($urandom_range(0, 15));
      demo = 1'($urandom_range(0, 1));
      p = demo ? 4 : 13;
      n = lim + 1;
      abort_t = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, n * p)) : 0;
      a_step  = (abort_t > 0) ? (abort_t - 1) / p : 0;
      start(lim, demo);
      for (int t = 1; t <= n * p + 3; t++) begin
        @(negedge clock);
        if (abort_t > 0 && t > abort_t) exp = idle_at(a_step);
        else exp = model(t, lim, demo);
        checks++;
        if (obs !== exp)
          $display("FAIL random run=%0d lim=%0d demo=%0d t=%0d: got %h want %h",
                   run, lim, demo, t, obs, exp);
        else passed++;
        limite = 4'($urandom);
        modo_demo = 1'($urandom);
        parar = (abort_t > 0 && t == abort_t);
      end
      parar = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_single_step();
    test_demo();
    test_abort();
    test_parar_priority();
    do_reset();
    test_ignored_inputs();
    do_reset();
    test_reset_mid();
    do_reset();
    test_no_wrap();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  // Watchdog: the bench must terminate on its own.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/controlador_exibicao_sequencia.md
CONTROLADOR_EXIBICAO_SEQUENCIA -- requirements
Module: controlador_exibicao_sequencia

Interface
REQ-001 The block SHALL have parameter T_ACESO, default 500, cycles each LED stays lit in normal mode.
REQ-002 The block SHALL have parameter T_APAGADO, default 250, cycles LEDs stay dark between steps in normal mode.
REQ-003 The block SHALL have parameter T_ACESO_DEMO, default 50, lit cycles in demo mode.
REQ-004 The block SHALL have parameter T_APAGADO_DEMO, default 25, dark cycles in demo mode.
REQ-005 The block SHALL have port clock  in  1  single system clock, rising edge.
REQ-006 The block SHALL have port reset  in  1  synchronous, active-high reset.
REQ-007 The block SHALL have port iniciar  in  1  start request, sampled only in OCIOSO.
REQ-008 The block SHALL have port parar  in  1  synchronous abort of playback.
REQ-009 The block SHALL have port limite  in  4  last memory address of the current round.
REQ-010 The block SHALL have port modo_demo  in  1  selects the demo timing parameters.
REQ-011 The block SHALL have port dado_memoria  in  4  LED code read from the sequence memory, 1-cycle synchronous read.
REQ-012 The block SHALL have port endereco  out  4  memory read address.
REQ-013 The block SHALL have port leds  out  4  LED drive.
REQ-014 The block SHALL have port exibindo  out  1  high in CARREGA, ACESO and APAGADO.
REQ-015 The block SHALL have port pronto  out  1  one-cycle completion pulse.
REQ-016 The block SHALL have port db_estado  out  3  state code: OCIOSO=0, CARREGA=1, ACESO=2, APAGADO=3, FIM=4.

Function
REQ-017 On entry from OCIOSO, the FSM SHALL register limite and modo_demo; mid-playback changes to those inputs SHALL have no effect.
REQ-018 OCIOSO with iniciar=1 SHALL go to CARREGA on the next cycle and clear endereco to 0; iniciar in any other state SHALL be ignored.
REQ-019 CARREGA SHALL last exactly 1 cycle and drive endereco; at its end dado_memoria SHALL be captured into dado_reg; next state is ACESO.
REQ-020 ACESO SHALL last exactly Ta cycles (T_ACESO, or T_ACESO_DEMO when the registered modo_demo=1) with leds=dado_reg; next state is APAGADO.
REQ-021 APAGADO SHALL last exactly Tp cycles (T_APAGADO or T_APAGADO_DEMO) with leds=0000.
REQ-022 At the end of APAGADO: if endereco==limite_reg, go to FIM; else increment endereco by 1 and go to CARREGA.
REQ-023 FIM SHALL assert pronto=1 for exactly 1 cycle and then return to OCIOSO.
REQ-024 leds SHALL be 0000 in every state except ACESO, and SHALL be decoded from registered state only.
REQ-025 Timing: if iniciar is sampled at edge k, for n=limite+1 steps, LED i SHALL be lit for cycles k+2+i*(1+Ta+Tp) through k+1+i*(1+Ta+Tp)+Ta, and pronto SHALL be high in cycle k+1+n*(1+Ta+Tp).
REQ-026 endereco SHALL never exceed limite_reg; with limite=15, addresses 0..15 SHALL be visited with no wrap to 0.
REQ-027 The duration counter SHALL be wide enough for max(all parameters) and SHALL reload on every state change.
REQ-028 parar=1 in any non-OCIOSO state SHALL force OCIOSO on the next cycle with leds=0000 and exibindo=0, and SHALL NOT produce a pronto pulse.
REQ-029 If parar and iniciar are both high in OCIOSO, parar SHALL win and the FSM SHALL stay in OCIOSO.
REQ-030 A parameter value of 0 SHALL NOT be supported; all timing parameters SHALL be >=1.

Reset
REQ-031 While reset=1 at a clock edge, the FSM SHALL enter OCIOSO with endereco=0, dado_reg=0, counter=0, leds=0000, exibindo=0, pronto=0, db_estado=0.
REQ-032 Reset SHALL take priority over iniciar and parar, and SHALL abort any playback without a pronto pulse.

Verification
Bench parameters for all scenarios: T_ACESO=8, T_APAGADO=4, T_ACESO_DEMO=2, T_APAGADO_DEMO=1; memory mem[i]=one-hot(i mod 4); iniciar pulses at cycle 0.
REQ-033 Single step: limite=0, modo_demo=0 -> leds=0001 in cycles 2..9, 0000 otherwise, pronto only in cycle 14.
REQ-034 Demo mode: limite=3, modo_demo=1 -> leds 0001, 0010, 0100, 1000 lit 2 cycles each, starting at cycles 2, 6, 10, 14; pronto in cycle 17.
REQ-035 Abort: limite=3, normal mode, parar=1 in cycle 20 (second ACESO) -> db_estado=0 and leds=0000 from cycle 21, pronto never asserted.
REQ-036 Ignored inputs: iniciar held high and limite changed to 0 during a limite=2 playback -> full 3-step sequence, exactly one pronto, then a new start because iniciar is still high in OCIOSO.
REQ-037 Reset mid-operation: reset=1 in cycle 5 -> all outputs at their reset values from cycle 6; a new iniciar afterwards replays from endereco=0.
REQ-038 No wrap: limite=15, demo mode -> endereco sequence 0..15 in order, pronto in cycle 65, endereco never returns to 0 before FIM.
